multicycle_cpu: RTL and testbench
=================================

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, datapath/register width (legal 8..32).
REQ-002 SHALL provide parameter ADDR_W, default 8, program counter and memory address width (legal 8..16).
REQ-003 SHALL provide parameter NREG, default 8, register count (fixed by 3-bit fields; other values illegal).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-006 imem_addr  out  ADDR_W  instruction fetch address.
REQ-007 imem_rdata  in  16  instruction word, valid one cycle after imem_addr is presented.
REQ-008 dmem_req  out  1  data access request, held until dmem_ready.
REQ-009 dmem_we  out  1  1=store, 0=load; valid while dmem_req.
REQ-010 dmem_addr  out  ADDR_W  data address (rs1 low ADDR_W bits, zero-extended if ADDR_W>DATA_W); valid while dmem_req.
REQ-011 dmem_wdata  out  DATA_W  store data; valid while dmem_req.
REQ-012 dmem_rdata  in  DATA_W  load data, sampled in the cycle dmem_ready=1.
REQ-013 dmem_ready  in  1  completes the pending access in the cycle it is high with dmem_req.
REQ-014 result  out  DATA_W  last ALU/LDI/LD writeback value.
REQ-015 carry_out  out  1  carry flag.
REQ-016 halted  out  1  high while in HALT state.
REQ-017 pc_out  out  ADDR_W  current program counter.

Function
REQ-018 Instruction SHALL decode as op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm=[7:0] (zero-extended to DATA_W/ADDR_W).
REQ-019 Opcodes: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR (rd=rs1 op rs2); 6 LDI rd=imm; 7 LD rd=mem[rs1]; 8 ST mem[rs1]=rs2; 9 JMP pc=imm; A BZ pc=imm if Z; B BC pc=imm if C; F HLT; C-E SHALL execute as NOP.
REQ-020 Register r0 SHALL read as 0; writes to r0 SHALL be discarded (result still updates).
REQ-021 FSM states: FETCH, DECODE, EXEC, MEM, HALT.
REQ-022 FETCH: drive imem_addr=pc; next DECODE.
REQ-023 DECODE: latch imem_rdata into IR, read rs1/rs2; next MEM for LD/ST, HALT for HLT, else EXEC.
REQ-024 EXEC: perform op, write rd, update flags/pc; next FETCH. ALU/LDI/jump/NOP instruction = exactly 3 cycles.
REQ-025 MEM: assert dmem_req; stay until dmem_ready=1; LD writes rd with dmem_rdata that cycle; next FETCH. LD/ST = 3 + wait cycles.
REQ-026 ADD: C = bit DATA_W of full sum; SUB: C = borrow (rs1<rs2 unsigned); logic ops clear C. Z = (ALU result==0). Only ops 1-5 update C and Z.
REQ-027 pc SHALL increment by 1 (mod 2^ADDR_W, wraps max->0) at every EXEC/MEM exit unless a taken jump loads imm.
REQ-028 HALT: hold all state, dmem_req=0, halted=1, until reset.
REQ-029 dmem_req SHALL be 0 outside MEM; dmem_addr/we/wdata SHALL remain stable while dmem_req=1 and dmem_ready=0.

Reset
REQ-030 reset=0 SHALL asynchronously set state=FETCH, pc=0, IR=0, all registers=0, C=Z=0, result=0, halted=0, dmem_req=0, dmem_we=0.
REQ-031 Reset asserted during MEM SHALL abort the access (dmem_req falls immediately); first fetch after release at address 0.

Verification
REQ-032 LDI r1,0xF0; LDI r2,0x20; ADD r3,r1,r2 (DATA_W=8) -> result=0x10, carry_out=1, Z=0, ADD completes 3 cycles after its fetch.
REQ-033 LDI r1,5; SUB r2,r1,r1; BZ 0x40 -> r2=0, Z=1, pc_out=0x40 after BZ.
REQ-034 ST r1->[r2] with dmem_ready delayed 4 cycles -> dmem_req high 5 cycles, addr/wdata stable; LD back -> rd equals stored value.
REQ-035 LDI r0,7; ADD r1,r0,r0 -> r1=0; pc at 0xFF executing NOP -> next fetch address 0x00.
REQ-036 HLT -> halted=1, pc_out frozen, no dmem_req for 20 cycles; reset pulse mid-MEM -> all outputs at REQ-030 values, fetch resumes at 0.
REQ-037 Repeat REQ-032 with DATA_W=16: 0x00F0+0x0020 -> result=0x0110, carry_out=0.

Source files
------------

// File: rtl/multicycle_cpu_if.sv
`default_nettype none
// ============================================================================
// multicycle_cpu_if : instruction-fetch and data-memory bus of multicycle_cpu
// Revision 1.0
// ============================================================================
interface multicycle_cpu_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, dmem_rdata, dmem_ready
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_cpu.sv
`default_nettype none
// ============================================================================
// multicycle_cpu : 16-bit-instruction multicycle CPU (FETCH/DECODE/EXEC/MEM/HALT)
// Revision 1.0
// ============================================================================
module multicycle_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREG   = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  multicycle_cpu_if.master   bus,
  output logic [DATA_W-1:0]  result,
  output logic               carry_out,
  output logic               halted,
  output logic [ADDR_W-1:0]  pc_out
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_LD  = 4'h7;
  localparam logic [3:0] OP_ST  = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_BZ  = 4'hA;
  localparam logic [3:0] OP_BC  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] opa, opb;
  logic              carry, zero;
  // Instruction register keeps only the fields used after DECODE; rs1/rs2
  // are consumed when the operands are read.
  logic [3:0]        ir_op;
  logic [2:0]        ir_rd;
  logic [7:0]        ir_imm;

  logic [3:0]        dec_op;
  logic [DATA_W:0]   alu_full;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              is_alu;
  logic              take_jump;
  logic [ADDR_W-1:0] pc_inc;
  logic [DATA_W-1:0] imm_d;
  logic [ADDR_W-1:0] imm_a;

  assign dec_op = bus.imem_rdata[15:12];
  assign imm_d  = DATA_W'(ir_imm);
  assign imm_a  = ADDR_W'(ir_imm);
  assign pc_inc = pc + ADDR_W'(1);

  always_comb begin
    alu_full = '0;
    is_alu   = 1'b1;
    case (ir_op)
      OP_ADD:  alu_full = {1'b0, opa} + {1'b0, opb};
      OP_SUB:  alu_full = {1'b0, opa} - {1'b0, opb};
      OP_AND:  alu_full = {1'b0, opa & opb};
      OP_OR:   alu_full = {1'b0, opa | opb};
      OP_XOR:  alu_full = {1'b0, opa ^ opb};
      default: is_alu   = 1'b0;
    endcase
  end

  // Bit DATA_W is the add carry or, for SUB, the borrow (rs1 < rs2).
  assign alu_res = alu_full[DATA_W-1:0];
  assign alu_c   = alu_full[DATA_W];

  always_comb begin
    take_jump = 1'b0;
    case (ir_op)
      OP_JMP:  take_jump = 1'b1;
      OP_BZ:   take_jump = zero;
      OP_BC:   take_jump = carry;
      default: take_jump = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   state_next = DECODE;
      DECODE: begin
        if (dec_op == OP_LD || dec_op == OP_ST) state_next = MEM;
        else if (dec_op == OP_HLT)              state_next = HALT;
        else                                    state_next = EXEC;
      end
      EXEC:    state_next = FETCH;
      MEM:     if (bus.dmem_ready) state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // regs[0] is never written, so it always reads back as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= '0;
      ir_op  <= '0;
      ir_rd  <= '0;
      ir_imm <= '0;
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      result <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        DECODE: begin
          ir_op  <= bus.imem_rdata[15:12];
          ir_rd  <= bus.imem_rdata[11:9];
          ir_imm <= bus.imem_rdata[7:0];
          opa    <= regs[bus.imem_rdata[8:6]];
          opb    <= regs[bus.imem_rdata[5:3]];
        end
        EXEC: begin
          pc <= take_jump ? imm_a : pc_inc;
          if (is_alu) begin
            result <= alu_res;
            carry  <= alu_c;
            zero   <= (alu_res == '0);
            if (ir_rd != '0) regs[ir_rd] <= alu_res;
          end else if (ir_op == OP_LDI) begin
            result <= imm_d;
            if (ir_rd != '0) regs[ir_rd] <= imm_d;
          end
        end
        MEM: begin
          if (bus.dmem_ready) begin
            pc <= pc_inc;
            if (ir_op == OP_LD) begin
              result <= bus.dmem_rdata;
              if (ir_rd != '0) regs[ir_rd] <= bus.dmem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Request is decoded from the state so an asynchronous reset drops it at once.
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = (state == MEM);
  assign bus.dmem_we    = (state == MEM) && (ir_op == OP_ST);
  assign bus.dmem_addr  = ADDR_W'(opa);
  assign bus.dmem_wdata = opb;

  assign halted    = (state == HALT);
  assign carry_out = carry;
  assign pc_out    = pc;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_cpu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_multicycle_cpu : directed vector bench for multicycle_cpu (8- and 16-bit)
// Revision 1.0
// ============================================================================
module tb_multicycle_cpu;
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic [7:0] pc;
  } vec_t;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic reset16 = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int wait_cnt = 0;
  logic mon_en = 1'b0;
  int st_cycles = 0;
  int ld_cycles = 0;
  int stab_err = 0;

  multicycle_cpu_if #(.DATA_W(8),  .ADDR_W(8)) bus ();
  multicycle_cpu_if #(.DATA_W(16), .ADDR_W(8)) bus16 ();

  logic [7:0]  result;
  logic        carry_out, halted;
  logic [7:0]  pc_out;
  logic [15:0] result16;
  logic        carry16, halted16;
  logic [7:0]  pc16;

  multicycle_cpu #(.DATA_W(8), .ADDR_W(8), .NREG(8)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .result(result), .carry_out(carry_out), .halted(halted), .pc_out(pc_out)
  );

  multicycle_cpu #(.DATA_W(16), .ADDR_W(8), .NREG(8)) dut16 (
    .clk(clk), .reset(reset16), .bus(bus16),
    .result(result16), .carry_out(carry16), .halted(halted16), .pc_out(pc16)
  );

  logic [15:0] imem   [256];
  logic [15:0] imem16 [256];
  logic [7:0]  dmem   [256];

  always @(posedge clk) bus.imem_rdata   <= imem[bus.imem_addr];
  always @(posedge clk) bus16.imem_rdata <= imem16[bus16.imem_addr];

  assign bus.dmem_ready   = bus.dmem_req && (wait_cnt >= lat);
  assign bus.dmem_rdata   = dmem[bus.dmem_addr];
  assign bus16.dmem_ready = 1'b1;
  assign bus16.dmem_rdata = '0;

  always @(posedge clk) begin
    if (!bus.dmem_req || bus.dmem_ready) wait_cnt <= 0;
    else                                 wait_cnt <= wait_cnt + 1;
    if (bus.dmem_req && bus.dmem_ready && bus.dmem_we)
      dmem[bus.dmem_addr] <= bus.dmem_wdata;
  end

  // Store/load observer for the memory-wait sequence: 0x3C to address 0x80.
  always @(negedge clk) begin
    if (mon_en && bus.dmem_req) begin
      if (bus.dmem_we) begin
        st_cycles++;
        if (bus.dmem_addr !== 8'h80 || bus.dmem_wdata !== 8'h3C) stab_err++;
      end else begin
        ld_cycles++;
        if (bus.dmem_addr !== 8'h80) stab_err++;
      end
    end
  end

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {4'h6, rd, 1'b0, imm};
  endfunction
  function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction
  function automatic logic [15:0] jt(input logic [3:0] op, input logic [7:0] imm);
    return {op, 4'h0, imm};
  endfunction
  function automatic logic [15:0] ld(input logic [2:0] rd, input logic [2:0] rs1);
    return {4'h7, rd, rs1, 6'b000000};
  endfunction
  function automatic logic [15:0] st(input logic [2:0] rs1, input logic [2:0] rs2);
    return {4'h8, 3'b000, rs1, rs2, 3'b000};
  endfunction
  localparam logic [15:0] HLT = 16'hF000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_until_halt(input int max, input string name);
    int n = 0;
    while (!halted && n < max) begin
      @(negedge clk);
      n++;
    end
    check({name, "_halt"}, 32'(halted), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    int   n;
    int   bad;

    vecs[0] = '{4'h1, 8'hF0, 8'h20, 8'h10, 1'b1, 8'h04};
    vecs[1] = '{4'h1, 8'h80, 8'h80, 8'h00, 1'b1, 8'h40};
    vecs[2] = '{4'h1, 8'h12, 8'h34, 8'h46, 1'b0, 8'h04};
    vecs[3] = '{4'h2, 8'h05, 8'h05, 8'h00, 1'b0, 8'h40};
    vecs[4] = '{4'h2, 8'h03, 8'h05, 8'hFE, 1'b1, 8'h04};
    vecs[5] = '{4'h3, 8'hF0, 8'h0F, 8'h00, 1'b0, 8'h40};
    vecs[6] = '{4'h4, 8'hA0, 8'h05, 8'hA5, 1'b0, 8'h04};
    vecs[7] = '{4'h5, 8'hFF, 8'h0F, 8'hF0, 1'b0, 8'h04};
    vecs[8] = '{4'h5, 8'h5A, 8'h5A, 8'h00, 1'b0, 8'h40};
    vecs[9] = '{4'hC, 8'h01, 8'h02, 8'h02, 1'b0, 8'h04};

    clear_imem();
    for (int i = 0; i < 256; i++) imem16[i] = 16'h0000;
    imem16[0] = ldi(3'd1, 8'hF0);
    imem16[1] = ldi(3'd2, 8'h20);
    imem16[2] = rr(4'h1, 3'd3, 3'd1, 3'd2);
    imem16[3] = HLT;

    // Reset state while both cores are held in reset.
    repeat (3) @(negedge clk);
    check("rst_result",  32'(result),       32'h0);
    check("rst_carry",   32'(carry_out),    32'h0);
    check("rst_halted",  32'(halted),       32'h0);
    check("rst_pc",      32'(pc_out),       32'h0);
    check("rst_req",     32'(bus.dmem_req), 32'h0);
    check("rst_we",      32'(bus.dmem_we),  32'h0);

    // 16-bit datapath: 0x00F0 + 0x0020 does not carry.
    reset16 = 1'b1;
    n = 0;
    while (!halted16 && n < 40) begin @(negedge clk); n++; end
    check("w16_halt",   32'(halted16), 32'd1);
    check("w16_result", 32'(result16), 32'h0110);
    check("w16_carry",  32'(carry16),  32'h0);

    // Exact 3-cycle timing of LDI, LDI, ADD.
    imem[0] = ldi(3'd1, 8'hF0);
    imem[1] = ldi(3'd2, 8'h20);
    imem[2] = rr(4'h1, 3'd3, 3'd1, 3'd2);
    imem[3] = HLT;
    do_reset();
    repeat (8) @(posedge clk);
    #1;
    check("tim_before_add", 32'(result), 32'h20);
    @(posedge clk);
    #1;
    check("tim_add_result", 32'(result),    32'h10);
    check("tim_add_carry",  32'(carry_out), 32'h1);
    check("tim_add_pc",     32'(pc_out),    32'h3);

    // ALU vector table; BZ 0x40 exposes the Z flag through the halt address.
    for (int v = 0; v < 10; v++) begin
      clear_imem();
      imem[0]     = ldi(3'd1, vecs[v].a);
      imem[1]     = ldi(3'd2, vecs[v].b);
      imem[2]     = rr(vecs[v].op, 3'd3, 3'd1, 3'd2);
      imem[3]     = jt(4'hA, 8'h40);
      imem[4]     = HLT;
      imem[8'h40] = HLT;
      do_reset();
      run_until_halt(40, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_result", v), 32'(result),    32'(vecs[v].res));
      check($sformatf("vec%0d_carry", v),  32'(carry_out), 32'(vecs[v].c));
      check($sformatf("vec%0d_pc", v),     32'(pc_out),    32'(vecs[v].pc));
    end

    // ADD sets C, BC is taken, AND then clears C.
    clear_imem();
    imem[0]     = ldi(3'd1, 8'hF0);
    imem[1]     = ldi(3'd2, 8'h20);
    imem[2]     = rr(4'h1, 3'd3, 3'd1, 3'd2);
    imem[3]     = jt(4'hB, 8'h50);
    imem[4]     = HLT;
    imem[8'h50] = rr(4'h3, 3'd4, 3'd1, 3'd2);
    imem[8'h51] = HLT;
    do_reset();
    run_until_halt(60, "bc");
    check("bc_pc",     32'(pc_out),    32'h51);
    check("bc_result", 32'(result),    32'h20);
    check("bc_carry",  32'(carry_out), 32'h0);

    // Store and load with a 4-cycle wait each.
    clear_imem();
    imem[0] = ldi(3'd1, 8'h3C);
    imem[1] = ldi(3'd2, 8'h80);
    imem[2] = st(3'd2, 3'd1);
    imem[3] = ld(3'd3, 3'd2);
    imem[4] = rr(4'h1, 3'd4, 3'd3, 3'd0);
    imem[5] = HLT;
    lat = 4;
    mon_en = 1'b1;
    do_reset();
    run_until_halt(100, "mem");
    mon_en = 1'b0;
    lat = 0;
    check("mem_st_req_cycles", 32'(st_cycles),   32'd5);
    check("mem_ld_req_cycles", 32'(ld_cycles),   32'd5);
    check("mem_stability",     32'(stab_err),    32'd0);
    check("mem_stored",        32'(dmem[8'h80]), 32'h3C);
    check("mem_ld_result",     32'(result),      32'h3C);
    check("mem_pc",            32'(pc_out),      32'h5);

    // r0 discards writes; PC wraps from 0xFF to 0x00.
    clear_imem();
    imem[0]     = ldi(3'd0, 8'h07);
    imem[1]     = rr(4'h1, 3'd1, 3'd0, 3'd0);
    imem[2]     = jt(4'h9, 8'hFF);
    imem[8'hFF] = 16'h0000;
    do_reset();
    n = 0;
    while (pc_out != 8'hFF && n < 30) begin @(negedge clk); n++; end
    check("wrap_reach_ff", 32'(pc_out), 32'hFF);
    check("r0_add_result", 32'(result), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("wrap_pc",        32'(pc_out),        32'h0);
    check("wrap_imem_addr", 32'(bus.imem_addr), 32'h0);

    // HLT freezes everything for 20 cycles.
    clear_imem();
    imem[0] = ldi(3'd1, 8'h03);
    imem[1] = HLT;
    imem[2] = st(3'd1, 3'd1);
    do_reset();
    run_until_halt(20, "hlt");
    check("hlt_pc", 32'(pc_out), 32'h1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!halted || pc_out != 8'h1 || bus.dmem_req || result != 8'h03) bad++;
    end
    check("hlt_frozen_20", 32'(bad), 32'd0);

    // Reset in the middle of a stalled store.
    clear_imem();
    imem[0] = ldi(3'd2, 8'h10);
    imem[1] = st(3'd2, 3'd1);
    imem[2] = HLT;
    lat = 1000;
    do_reset();
    n = 0;
    while (!bus.dmem_req && n < 30) begin @(negedge clk); n++; end
    check("abort_mem_reached", 32'(bus.dmem_req), 32'h1);
    check("abort_pre_result",  32'(result),       32'h10);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_req",    32'(bus.dmem_req), 32'h0);
    check("abort_we",     32'(bus.dmem_we),  32'h0);
    check("abort_pc",     32'(pc_out),       32'h0);
    check("abort_result", 32'(result),       32'h0);
    check("abort_carry",  32'(carry_out),    32'h0);
    check("abort_halted", 32'(halted),       32'h0);
    lat = 0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_fetch_addr", 32'(bus.imem_addr), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_rerun_result", 32'(result), 32'h10);
    check("abort_rerun_pc",     32'(pc_out), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
